// File: rtl/traffic_pkg.sv
// traffic_pkg: shared lamp encodings, monitor state and fault cause types,
// plus small helpers that classify lamp codes and legal transitions.
package traffic_pkg;

    typedef logic [2:0] lamp_t;

    localparam lamp_t RED = 3'b100;
    localparam lamp_t YEL = 3'b010;
    localparam lamp_t GRN = 3'b001;
    localparam lamp_t OFF = 3'b000;

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FAULT
    } mon_state_t;

    // Numeric value doubles as priority: lower code wins when several fire.
    typedef enum logic [2:0] {
        NONE         = 3'd0,
        ILLEGAL_CODE = 3'd1,
        CONFLICT     = 3'd2,
        BAD_SEQ      = 3'd3,
        SHORT_YEL    = 3'd4
    } fault_code_t;

    // True for the three one-hot codes a controller may legally emit.
    function automatic logic is_legal(input lamp_t l);
        return (l == RED) || (l == YEL) || (l == GRN);
    endfunction

    // True when the direction is letting traffic move (yellow or green).
    function automatic logic is_go(input lamp_t l);
        return (l == YEL) || (l == GRN);
    endfunction

    // A direction may hold its code or advance R->G, G->Y, Y->R only.
    function automatic logic seq_ok(input lamp_t prev, input lamp_t cur);
        return (cur == prev) ||
               ((prev == RED) && (cur == GRN)) ||
               ((prev == GRN) && (cur == YEL)) ||
               ((prev == YEL) && (cur == RED));
    endfunction

endpackage

// File: rtl/traffic_tick_gen.sv
// traffic_tick_gen: free-running divider producing a one-clock tick pulse
// every TICK_DIV clocks. Only reset restarts it.
module traffic_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Count 0..TICK_DIV-1 and wrap; the tick marks the last count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: safety stage between the signal controller and the
// physical lamps. Passes the controller outputs through while they are sane,
// and latches a flashing-red fault on illegal codes, crossing conflicts,
// illegal sequencing or a short yellow until an operator clears it.
// Build macro FAULT_COUNT_EN adds a saturating fault_count output.
module traffic_lamp_monitor
    import traffic_pkg::*;
#(
    parameter int TICK_DIV    = 100_000_000,
    parameter int MIN_YELLOW  = 3,
    parameter int INIT_TICKS  = 2,
    parameter int BLINK_TICKS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] north_dir,
    input  logic [2:0] south_dir,
    input  logic [2:0] east_dir,
    input  logic [2:0] west_dir,
    input  logic       fault_clr,
    output logic [2:0] north_lamp,
    output logic [2:0] south_lamp,
    output logic [2:0] east_lamp,
    output logic [2:0] west_lamp,
    output logic       fault,
    output logic [2:0] fault_code
`ifdef FAULT_COUNT_EN
    ,
    output logic [7:0] fault_count
`endif
);

    localparam int DW = (MIN_YELLOW > 0) ? $clog2(MIN_YELLOW + 1) : 1;
    localparam int AW = (INIT_TICKS > 1) ? $clog2(INIT_TICKS + 1) : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS + 1) : 1;

    localparam logic [DW-1:0] MIN_YEL_C  = DW'(MIN_YELLOW);
    localparam logic [AW-1:0] INIT_LAST  = AW'(INIT_TICKS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

    // Direction index order: 0 north, 1 south, 2 east, 3 west.
    lamp_t           dir_in  [4];
    lamp_t           lamp_q  [4];
    lamp_t           prev_q  [4];
    logic [DW-1:0]   dwell_q [4];

    mon_state_t      state;
    fault_code_t     code_q;
    fault_code_t     code_d;
    logic [AW-1:0]   allred_q;
    logic [BW-1:0]   blink_q;
    logic            blink_on;
    logic            all_red;
    logic            tick;

    logic            any_illegal;
    logic            any_bad_seq;
    logic            any_short;
    logic            ns_go;
    logic            ew_go;

`ifdef FAULT_COUNT_EN
    logic [7:0]      count_q;
    assign fault_count = count_q;
`endif

    assign dir_in[0] = north_dir;
    assign dir_in[1] = south_dir;
    assign dir_in[2] = east_dir;
    assign dir_in[3] = west_dir;

    assign north_lamp = lamp_q[0];
    assign south_lamp = lamp_q[1];
    assign east_lamp  = lamp_q[2];
    assign west_lamp  = lamp_q[3];
    assign fault_code = code_q;

    assign all_red = (dir_in[0] == RED) && (dir_in[1] == RED) &&
                     (dir_in[2] == RED) && (dir_in[3] == RED);

    traffic_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Evaluate every safety check on the current inputs and pick the
    // lowest-numbered cause so the latched code is deterministic.
    always_comb begin
        any_illegal = 1'b0;
        any_bad_seq = 1'b0;
        any_short   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!is_legal(dir_in[i])) any_illegal = 1'b1;
            if (!seq_ok(prev_q[i], dir_in[i])) any_bad_seq = 1'b1;
            if ((prev_q[i] == YEL) && (dir_in[i] == RED) && (dwell_q[i] < MIN_YEL_C))
                any_short = 1'b1;
        end
        ns_go = is_go(dir_in[0]) || is_go(dir_in[1]);
        ew_go = is_go(dir_in[2]) || is_go(dir_in[3]);

        if (any_illegal)          code_d = ILLEGAL_CODE;
        else if (ns_go && ew_go)  code_d = CONFLICT;
        else if (any_bad_seq)     code_d = BAD_SEQ;
        else if (any_short)       code_d = SHORT_YEL;
        else                      code_d = NONE;
    end

    // Monitor FSM: all-red qualification, pass-through with checking, and
    // latched flashing-red fault. Lamps are forced on the same edge that
    // detects a fault so an unsafe pattern never reaches the outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= INIT;
            code_q   <= NONE;
            fault    <= 1'b0;
            allred_q <= '0;
            blink_q  <= '0;
            blink_on <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                lamp_q[i]  <= RED;
                prev_q[i]  <= RED;
                dwell_q[i] <= '0;
            end
`ifdef FAULT_COUNT_EN
            count_q <= '0;
`endif
        end else begin
            case (state)
                INIT: begin
                    for (int i = 0; i < 4; i++) lamp_q[i] <= RED;
                    if (!all_red) begin
                        allred_q <= '0;
                    end else if (tick) begin
                        if (allred_q == INIT_LAST) begin
                            state    <= RUN;
                            allred_q <= '0;
                            for (int i = 0; i < 4; i++) begin
                                prev_q[i]  <= RED;
                                dwell_q[i] <= '0;
                            end
                        end else begin
                            allred_q <= allred_q + 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (code_d != NONE) begin
                        state    <= FAULT;
                        fault    <= 1'b1;
                        code_q   <= code_d;
                        blink_q  <= '0;
                        blink_on <= 1'b1;
                        for (int i = 0; i < 4; i++) lamp_q[i] <= RED;
`ifdef FAULT_COUNT_EN
                        if (count_q != 8'hFF) count_q <= count_q + 1'b1;
`endif
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            lamp_q[i] <= dir_in[i];
                            prev_q[i] <= dir_in[i];
                            // Yellow dwell counts ticks while the input is yellow.
                            if (dir_in[i] == YEL) begin
                                if (tick && (dwell_q[i] != MIN_YEL_C))
                                    dwell_q[i] <= dwell_q[i] + 1'b1;
                            end else begin
                                dwell_q[i] <= '0;
                            end
                        end
                    end
                end

                FAULT: begin
                    if (fault_clr && all_red) begin
                        state    <= INIT;
                        fault    <= 1'b0;
                        code_q   <= NONE;
                        allred_q <= '0;
                        for (int i = 0; i < 4; i++) lamp_q[i] <= RED;
                    end else if (tick) begin
                        if (blink_q == BLINK_LAST) begin
                            blink_q  <= '0;
                            blink_on <= !blink_on;
                            for (int i = 0; i < 4; i++) lamp_q[i] <= blink_on ? OFF : RED;
                        end else begin
                            blink_q <= blink_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// tb_traffic_lamp_monitor: directed bench for traffic_lamp_monitor with
// TICK_DIV=4, MIN_YELLOW=3, INIT_TICKS=2, BLINK_TICKS=2.
// Define FAULT_COUNT_EN to also exercise the fault counter.
module tb_traffic_lamp_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [11:0] ALL_RED = 12'b100_100_100_100;
  localparam logic [11:0] ALL_OFF = 12'b000_000_000_000;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] north_dir, south_dir, east_dir, west_dir;
  logic       fault_clr;
  logic [2:0] north_lamp, south_lamp, east_lamp, west_lamp;
  logic       fault;
  logic [2:0] fault_code;
`ifdef FAULT_COUNT_EN
  logic [7:0] fault_count;
`endif
  logic [11:0] lamps_all;

  int checks = 0;
  int errors = 0;
  int exp_faults = 0;

  assign lamps_all = {north_lamp, south_lamp, east_lamp, west_lamp};

  // clock / reset
  always #5 clk = ~clk;

  traffic_lamp_monitor #(
    .TICK_DIV    (4),
    .MIN_YELLOW  (3),
    .INIT_TICKS  (2),
    .BLINK_TICKS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .north_dir  (north_dir),
    .south_dir  (south_dir),
    .east_dir   (east_dir),
    .west_dir   (west_dir),
    .fault_clr  (fault_clr),
    .north_lamp (north_lamp),
    .south_lamp (south_lamp),
    .east_lamp  (east_lamp),
    .west_lamp  (west_lamp),
    .fault      (fault),
    .fault_code (fault_code)
`ifdef FAULT_COUNT_EN
    ,
    .fault_count(fault_count)
`endif
  );

  // driver tasks
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_dirs(input logic [2:0] n, input logic [2:0] s,
                          input logic [2:0] e, input logic [2:0] w);
    north_dir = n;
    south_dir = s;
    east_dir  = e;
    west_dir  = w;
  endtask

  // Clear a latched fault with all inputs red, then hold red long enough
  // (two ticks) for the monitor to qualify and re-enter RUN.
  task automatic clear_and_run();
    set_dirs(R, R, R, R);
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    step(8);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    fault_clr = 1'b0;
    set_dirs(R, R, R, R);
    step(3);
    checks++;
    if (lamps_all !== ALL_RED) begin
      errors++;
      $display("FAIL reset_lamps: got %b expected %b", lamps_all, ALL_RED);
    end
    checks++;
    if ({fault, fault_code} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_fault: got fault=%b code=%0d expected fault=0 code=0", fault, fault_code);
    end
  endtask

  // Release at edge e1; ticks fall on e4, e8, e12, e16.
  task automatic test_init();
    reset = 1'b1;
    step(2);
    set_dirs(G, R, R, R);
    step(1);
    checks++;
    if (lamps_all !== ALL_RED || fault !== 1'b0) begin
      errors++;
      $display("FAIL init_mask: got lamps=%b fault=%b expected lamps=%b fault=0", lamps_all, fault, ALL_RED);
    end
    set_dirs(R, R, R, R);
    step(4);
    set_dirs(G, R, R, R);
    step(1);
    checks++;
    if (lamps_all !== ALL_RED || fault !== 1'b0) begin
      errors++;
      $display("FAIL init_not_early: got lamps=%b fault=%b expected lamps=%b fault=0", lamps_all, fault, ALL_RED);
    end
    set_dirs(R, R, R, R);
    step(8);
    set_dirs(G, R, R, R);
    step(1);
    checks++;
    if (lamps_all !== {G, R, R, R} || fault !== 1'b0) begin
      errors++;
      $display("FAIL run_entry: got lamps=%b fault=%b expected lamps=%b fault=0", lamps_all, fault, {G, R, R, R});
    end
  endtask

  task automatic test_yellow_dwell();
    fault_clr = 1'b1;
    set_dirs(G, G, R, R);
    step(1);
    fault_clr = 1'b0;
    checks++;
    if (lamps_all !== {G, G, R, R} || fault !== 1'b0) begin
      errors++;
      $display("FAIL ns_green: got lamps=%b fault=%b expected lamps=%b fault=0", lamps_all, fault, {G, G, R, R});
    end
    set_dirs(Y, Y, R, R);
    for (int i = 0; i < 12; i++) begin
      step(1);
      checks++;
      if (lamps_all !== {Y, Y, R, R}) begin
        errors++;
        $display("FAIL ns_yellow_hold: cycle %0d got %b expected %b", i, lamps_all, {Y, Y, R, R});
      end
    end
    set_dirs(R, R, R, R);
    step(1);
    checks++;
    if (lamps_all !== ALL_RED || {fault, fault_code} !== 4'b0000) begin
      errors++;
      $display("FAIL ns_yellow_to_red: got lamps=%b fault=%b code=%0d expected lamps=%b fault=0 code=0",
               lamps_all, fault, fault_code, ALL_RED);
    end
    set_dirs(R, R, G, G);
    step(1);
    checks++;
    if (lamps_all !== {R, R, G, G}) begin
      errors++;
      $display("FAIL ew_green: got %b expected %b", lamps_all, {R, R, G, G});
    end
    set_dirs(R, R, Y, Y);
    step(12);
    set_dirs(R, R, R, R);
    step(1);
    checks++;
    if (lamps_all !== ALL_RED || {fault, fault_code} !== 4'b0000) begin
      errors++;
      $display("FAIL ew_cycle: got lamps=%b fault=%b code=%0d expected lamps=%b fault=0 code=0",
               lamps_all, fault, fault_code, ALL_RED);
    end
  endtask

  task automatic test_conflict_blink();
    int n;
    set_dirs(G, R, G, R);
    step(1);
    exp_faults++;
    checks++;
    if ({fault, fault_code} !== 4'b1010 || lamps_all !== ALL_RED) begin
      errors++;
      $display("FAIL conflict: got fault=%b code=%0d lamps=%b expected fault=1 code=2 lamps=%b",
               fault, fault_code, lamps_all, ALL_RED);
    end
    set_dirs(R, R, R, R);
    n = 0;
    while (lamps_all !== ALL_OFF && n < 8) begin
      step(1);
      n++;
    end
    checks++;
    if (lamps_all !== ALL_OFF) begin
      errors++;
      $display("FAIL blink_first_off: got %b expected %b within 8 cycles", lamps_all, ALL_OFF);
    end
    for (int k = 1; k < 8; k++) begin
      step(1);
      checks++;
      if (lamps_all !== ALL_OFF) begin
        errors++;
        $display("FAIL blink_off_hold: cycle %0d got %b expected %b", k, lamps_all, ALL_OFF);
      end
    end
    step(1);
    checks++;
    if (lamps_all !== ALL_RED || {fault, fault_code} !== 4'b1010) begin
      errors++;
      $display("FAIL blink_back_red: got lamps=%b fault=%b code=%0d expected lamps=%b fault=1 code=2",
               lamps_all, fault, fault_code, ALL_RED);
    end
    fault_clr = 1'b1;
    step(1);
    fault_clr = 1'b0;
    checks++;
    if ({fault, fault_code} !== 4'b0000 || lamps_all !== ALL_RED) begin
      errors++;
      $display("FAIL conflict_clear: got fault=%b code=%0d lamps=%b expected fault=0 code=0 lamps=%b",
               fault, fault_code, lamps_all, ALL_RED);
    end
    step(8);
  endtask

  task automatic test_priority_seq();
    set_dirs(G, 3'b011, G, R);
    step(1);
    exp_faults++;
    checks++;
    if ({fault, fault_code} !== 4'b1001 || lamps_all !== ALL_RED) begin
      errors++;
      $display("FAIL illegal_priority: got fault=%b code=%0d lamps=%b expected fault=1 code=1 lamps=%b",
               fault, fault_code, lamps_all, ALL_RED);
    end
    clear_and_run();
    set_dirs(G, R, R, R);
    step(1);
    checks++;
    if (lamps_all !== {G, R, R, R} || fault !== 1'b0) begin
      errors++;
      $display("FAIL seq_green: got lamps=%b fault=%b expected lamps=%b fault=0", lamps_all, fault, {G, R, R, R});
    end
    set_dirs(R, R, R, R);
    step(1);
    exp_faults++;
    checks++;
    if ({fault, fault_code} !== 4'b1011) begin
      errors++;
      $display("FAIL bad_seq: got fault=%b code=%0d expected fault=1 code=3", fault, fault_code);
    end
    clear_and_run();
  endtask

  task automatic test_short_yel_clear();
    set_dirs(G, R, R, R);
    step(1);
    set_dirs(Y, R, R, R);
    step(4);
    checks++;
    if (lamps_all !== {Y, R, R, R} || fault !== 1'b0) begin
      errors++;
      $display("FAIL short_yel_setup: got lamps=%b fault=%b expected lamps=%b fault=0", lamps_all, fault, {Y, R, R, R});
    end
    set_dirs(R, R, R, R);
    step(1);
    exp_faults++;
    checks++;
    if ({fault, fault_code} !== 4'b1100 || lamps_all !== ALL_RED) begin
      errors++;
      $display("FAIL short_yel: got fault=%b code=%0d lamps=%b expected fault=1 code=4 lamps=%b",
               fault, fault_code, lamps_all, ALL_RED);
    end
    fault_clr = 1'b1;
    set_dirs(R, R, R, G);
    step(3);
    checks++;
    if ({fault, fault_code} !== 4'b1100) begin
      errors++;
      $display("FAIL clr_ignored: got fault=%b code=%0d expected fault=1 code=4", fault, fault_code);
    end
    set_dirs(R, R, R, R);
    step(1);
    fault_clr = 1'b0;
    checks++;
    if ({fault, fault_code} !== 4'b0000 || lamps_all !== ALL_RED) begin
      errors++;
      $display("FAIL clr_accept: got fault=%b code=%0d lamps=%b expected fault=0 code=0 lamps=%b",
               fault, fault_code, lamps_all, ALL_RED);
    end
    step(8);
    set_dirs(G, R, R, R);
    step(1);
    checks++;
    if (lamps_all !== {G, R, R, R} || fault !== 1'b0) begin
      errors++;
      $display("FAIL rerun_after_clr: got lamps=%b fault=%b expected lamps=%b fault=0", lamps_all, fault, {G, R, R, R});
    end
  endtask

  task automatic test_reset_in_fault();
    set_dirs(G, R, G, R);
    step(1);
    exp_faults++;
    checks++;
    if ({fault, fault_code} !== 4'b1010) begin
      errors++;
      $display("FAIL conflict_again: got fault=%b code=%0d expected fault=1 code=2", fault, fault_code);
    end
    set_dirs(R, R, R, R);
    step(5);
`ifdef FAULT_COUNT_EN
    checks++;
    if (fault_count !== 8'(exp_faults)) begin
      errors++;
      $display("FAIL fault_count_total: got %0d expected %0d", fault_count, exp_faults);
    end
`endif
    reset = 1'b0;
    step(1);
    checks++;
    if (lamps_all !== ALL_RED || {fault, fault_code} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_fault: got lamps=%b fault=%b code=%0d expected lamps=%b fault=0 code=0",
               lamps_all, fault, fault_code, ALL_RED);
    end
`ifdef FAULT_COUNT_EN
    checks++;
    if (fault_count !== 8'd0) begin
      errors++;
      $display("FAIL fault_count_reset: got %0d expected 0", fault_count);
    end
`endif
    reset = 1'b1;
    set_dirs(G, R, R, R);
    step(1);
    checks++;
    if (lamps_all !== ALL_RED || fault !== 1'b0) begin
      errors++;
      $display("FAIL init_after_reset: got lamps=%b fault=%b expected lamps=%b fault=0", lamps_all, fault, ALL_RED);
    end
`ifdef FAULT_COUNT_EN
    for (int i = 0; i < 300; i++) begin
      set_dirs(R, R, R, R);
      step(8);
      set_dirs(G, R, G, R);
      step(1);
      set_dirs(R, R, R, R);
      fault_clr = 1'b1;
      step(1);
      fault_clr = 1'b0;
      if (i == 0) begin
        checks++;
        if (fault_count !== 8'd1) begin
          errors++;
          $display("FAIL fault_count_first: got %0d expected 1", fault_count);
        end
      end
    end
    checks++;
    if (fault_count !== 8'd255) begin
      errors++;
      $display("FAIL fault_count_saturate: got %0d expected 255", fault_count);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_init();
    test_yellow_dwell();
    test_conflict_blink();
    test_priority_seq();
    test_short_yel_clear();
    test_reset_in_fault();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/traffic_lamp_monitor.md
Name: traffic_lamp_monitor

Overview:
Safety stage directly downstream of top_trafficsignal. It consumes the four 3-bit direction outputs and checks them for illegal encodings, N/S vs E/W conflicts, illegal sequencing and short yellow. It drives the physical lamp outputs: pass-through when healthy, latched flashing-red on any fault until cleared by an operator.

Parameters:
TICK_DIV, 100_000_000, clk cycles per tick (1 s at 100 MHz)
MIN_YELLOW, 3, minimum yellow dwell in ticks
INIT_TICKS, 2, ticks of all-red input required before RUN
BLINK_TICKS, 1, ticks per half-period of fault flash

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
north_dir  in  3  controller output {red,yellow,green}
south_dir  in  3  same
east_dir  in  3  same
west_dir  in  3  same
fault_clr  in  1  operator clear request (level)
north_lamp  out  3  driven lamp
south_lamp  out  3  driven lamp
east_lamp  out  3  driven lamp
west_lamp  out  3  driven lamp
fault  out  1  latched fault flag
fault_code  out  3  cause of the latched fault (0 = none)

Behaviour:
- Interface: one clock. Reset is synchronous and active-low: state is cleared on a clk edge while reset==0.
- Legal lamp codes: RED=3'b100, YEL=3'b010, GRN=3'b001. Any other code is illegal.
- Reset values: all lamps=RED, fault=0, fault_code=0, state=INIT, tick counter=0, blink phase=on, dwell counters=0.
- Tick: the internal counter pulses for 1 clk every TICK_DIV clks; it is free-running and reset only by reset.
- Outputs are registered, with 1-cycle latency. Inputs sampled at edge k appear on the lamps after edge k. A fault detected on those inputs sets fault, fault_code and the forced lamps at the same edge k, so an unsafe pattern never reaches the lamps.
- INIT state:
  - Lamps are RED.
  - The all-red counter increments on each tick while all four inputs==RED; any non-RED input resets it to 0.
  - At INIT_TICKS the block enters RUN and each per-direction prev register is loaded with RED.
- RUN state: lamps=inputs. Checks run every cycle. If several fire, the lowest code wins:
  - 1 ILLEGAL_CODE: any input not legal.
  - 2 CONFLICT: (N or S in {YEL,GRN}) and (E or W in {YEL,GRN}).
  - 3 BAD_SEQ: a per-direction change that is not R->G, G->Y or Y->R, compared against prev.
  - 4 SHORT_YEL: a Y->R change with that direction's yellow dwell < MIN_YELLOW.
- Dwell counters (per direction): increment on each tick while that direction is YEL, saturating at MIN_YELLOW. Cleared on leaving YEL.
- On any fault: go to FAULT, fault=1, fault_code latched.
- FAULT state:
  - All lamps toggle between RED and 3'b000 every BLINK_TICKS ticks, starting on RED.
  - Checks are suspended.
  - fault_clr==1 with all inputs==RED: on the next edge go to INIT with fault=0, fault_code=0 and the all-red counter cleared.
  - fault_clr with any non-RED input is ignored.
- fault_clr outside FAULT: no effect.
- Reset mid-operation (any state): next edge returns to the reset values.

Optional Feature:
Macro FAULT_COUNT_EN.
- Defined: adds output fault_count[7:0], reset 0. It increments by 1 on every RUN->FAULT entry, saturates at 255, and is not cleared by fault_clr (only by reset).
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package traffic_pkg:
  - lamp_t (logic[2:0]) with constants RED/YEL/GRN/OFF.
  - mon_state_t enum {INIT,RUN,FAULT}.
  - fault_code_t enum {NONE=0,ILLEGAL_CODE=1,CONFLICT=2,BAD_SEQ=3,SHORT_YEL=4}.
- Sub-module traffic_tick_gen(TICK_DIV): produces the 1-cycle tick pulse, is reused by the controller, and is instantiated once here.

Test Plan:
(Use TICK_DIV=4, MIN_YELLOW=3, INIT_TICKS=2, BLINK_TICKS=2.)
1. Reset low 3 cycles, then release with all inputs RED -> lamps=100 throughout. RUN is entered after 2 ticks (8 clks), then lamps follow the inputs with 1-cycle latency.
2. In RUN, N/S sequence GRN -> YEL held 12 clks (3 ticks) -> RED, with E/W RED -> no fault; lamps mirror the inputs.
3. In RUN, north=GRN and east=GRN in the same cycle -> next edge: fault=1, fault_code=2, all lamps=100. Lamps then alternate 100/000 every 8 clks.
4. In RUN, south=3'b011 and east=GRN simultaneously -> fault_code=1 (priority over CONFLICT). Separately, north GRN->RED directly -> fault_code=3.
5. North YEL held 4 clks then RED -> fault_code=4. Then fault_clr=1 with west=GRN -> stays in FAULT. Then fault_clr=1 with all RED -> fault=0, INIT, RUN again after 8 clks.
6. Assert reset low during FAULT mid-blink -> next edge: lamps=100, fault=0, fault_code=0, INIT. With FAULT_COUNT_EN, fault_count returns to 0 only here; 300 forced faults -> fault_count=255.
